csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer for the RV32I core. It executes retiring CSR instructions against the M-mode CSRs and arbitrates synchronous exceptions, level-sensitive M-mode interrupts, MRET and WFI. It issues a registered PC redirect to the fetch stage. It sits beside writeback and consumes the decode/execute outputs for the retiring instruction.

---
 rtl/csr_trap_unit_pkg.sv | 69 ++++++
 rtl/csr_trap_unit_irq_arbiter.sv | 22 ++
 rtl/csr_trap_unit.sv | 193 +++++++++++++++++++
 tb/tb_csr_trap_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_trap_unit_pkg.sv
// Shared RISC-V definitions for the M-mode CSR file and trap sequencer.
// Holds the CSR addresses, cause codes, bit positions and the read-modify-write helper.
package csr_trap_unit_pkg;

  typedef enum logic [2:0] {
    CSRRW  = 3'b001,
    CSRRS  = 3'b010,
    CSRRC  = 3'b011,
    CSRRWI = 3'b101,
    CSRRSI = 3'b110,
    CSRRCI = 3'b111
  } funct3_type_system_e;

  typedef enum logic [11:0] {
    CSR_MSTATUS  = 12'h300,
    CSR_MIE      = 12'h304,
    CSR_MTVEC    = 12'h305,
    CSR_MSCRATCH = 12'h340,
    CSR_MEPC     = 12'h341,
    CSR_MCAUSE   = 12'h342,
    CSR_MTVAL    = 12'h343,
    CSR_MIP      = 12'h344
  } csr_addr_e;

  typedef enum logic [30:0] {
    EXC_INSTR_MISALIGNED = 31'd0,
    EXC_INSTR_ACCESS     = 31'd1,
    EXC_ILLEGAL_INSTR    = 31'd2,
    EXC_BREAKPOINT       = 31'd3,
    EXC_LOAD_MISALIGNED  = 31'd4,
    EXC_LOAD_ACCESS      = 31'd5,
    EXC_STORE_MISALIGNED = 31'd6,
    EXC_STORE_ACCESS     = 31'd7,
    EXC_ECALL_M          = 31'd11
  } exception_code_e;

  typedef enum logic [30:0] {
    IRQ_SW_M    = 31'd3,
    IRQ_TIMER_M = 31'd7,
    IRQ_EXT_M   = 31'd11
  } interrupt_code_e;

  typedef enum logic {
    TRAP_STATE_RUN   = 1'b0,
    TRAP_STATE_SLEEP = 1'b1
  } csr_trap_state_e;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIX_MSI_BIT      = 3;
  localparam int MIX_MTI_BIT      = 7;
  localparam int MIX_MEI_BIT      = 11;

  localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  // New CSR value for a write/set/clear op; non-write encodings leave the value untouched.
  function automatic logic [31:0] csr_modify(input logic [2:0] op, input logic [31:0] old,
                                             input logic [31:0] wdata);
    case (op)
      CSRRW, CSRRWI: csr_modify = wdata;
      CSRRS, CSRRSI: csr_modify = old | wdata;
      CSRRC, CSRRCI: csr_modify = old & ~wdata;
      default:       csr_modify = old;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_irq_arbiter.sv
// Fixed-priority M-mode interrupt selection: external > software > timer.
module csr_irq_arbiter
  import csr_trap_unit_pkg::*;
(
  input  logic [31:0]     pending,
  output logic            valid,
  output interrupt_code_e code
);

  logic unused_pending;
  assign unused_pending = ^{pending[31:12], pending[10:8], pending[6:4], pending[2:0]};

  always_comb begin
    valid = 1'b1;
    code  = IRQ_EXT_M;
    if (pending[MIX_MEI_BIT])      code = IRQ_EXT_M;
    else if (pending[MIX_MSI_BIT]) code = IRQ_SW_M;
    else if (pending[MIX_MTI_BIT]) code = IRQ_TIMER_M;
    else                           valid = 1'b0;
  end

endmodule

// File: rtl/csr_trap_unit.sv
// M-mode CSR file and trap sequencer: CSR ops, exceptions, interrupts, MRET and WFI,
// with a registered one-cycle PC redirect towards fetch.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        csr_req_i,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        csr_src_zero_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        exc_valid_i,
  input  logic [30:0] exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        wfi_i,
  input  logic        boundary_i,
  input  logic [31:0] next_pc_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        sleep_o
);

  csr_trap_state_e state_reg, state_next;
  logic        status_mie_reg, status_mie_next, status_mpie_reg, status_mpie_next;
  logic [31:0] mie_reg, mie_next, mtvec_reg, mtvec_next, mscratch_reg, mscratch_next;
  logic [31:0] mepc_reg, mepc_next, mcause_reg, mcause_next, mtval_reg, mtval_next;
  logic        redirect_reg, redirect_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;

  logic [31:0] mip, pending, mstatus, csr_wval, tvec_base;
  logic        csr_known, csr_we, irq_valid, trap, trap_irq;
  logic [30:0] trap_code;
  interrupt_code_e irq_code;

  always_comb begin
    mip = '0;
    mip[MIX_MSI_BIT] = irq_sw_i;
    mip[MIX_MTI_BIT] = irq_timer_i;
    mip[MIX_MEI_BIT] = irq_ext_i;
    mstatus = '0;
    mstatus[12:11] = 2'b11;
    mstatus[MSTATUS_MIE_BIT]  = status_mie_reg;
    mstatus[MSTATUS_MPIE_BIT] = status_mpie_reg;
  end

  assign pending   = mie_reg & mip;
  assign tvec_base = {mtvec_reg[31:2], 2'b00};

  csr_irq_arbiter u_irq_arbiter (
    .pending (pending),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  always_comb begin
    csr_known   = 1'b1;
    csr_rdata_o = '0;
    case (csr_addr_i)
      CSR_MSTATUS:  csr_rdata_o = mstatus;
      CSR_MIE:      csr_rdata_o = mie_reg;
      CSR_MTVEC:    csr_rdata_o = mtvec_reg;
      CSR_MSCRATCH: csr_rdata_o = mscratch_reg;
      CSR_MEPC:     csr_rdata_o = mepc_reg;
      CSR_MCAUSE:   csr_rdata_o = mcause_reg;
      CSR_MTVAL:    csr_rdata_o = mtval_reg;
      CSR_MIP:      csr_rdata_o = mip;
      default:      csr_known   = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_req_i && !csr_known;
  assign csr_wval      = csr_modify(csr_op_i, csr_rdata_o, csr_wdata_i);
  // Set/clear with a zero source is a pure read and must not disturb the CSR.
  assign csr_we = csr_req_i && csr_known &&
                  ((csr_op_i inside {CSRRW, CSRRWI}) ||
                   ((csr_op_i inside {CSRRS, CSRRC, CSRRSI, CSRRCI}) && !csr_src_zero_i));

  always_comb begin
    state_next       = state_reg;
    status_mie_next  = status_mie_reg;
    status_mpie_next = status_mpie_reg;
    mie_next         = mie_reg;
    mtvec_next       = mtvec_reg;
    mscratch_next    = mscratch_reg;
    mepc_next        = mepc_reg;
    mcause_next      = mcause_reg;
    mtval_next       = mtval_reg;
    redirect_next    = 1'b0;
    redirect_pc_next = redirect_pc_reg;
    trap             = 1'b0;
    trap_irq         = 1'b0;
    trap_code        = '0;

    case (state_reg)
      TRAP_STATE_SLEEP: begin
        // Wake on any enabled pending line; only trap if interrupts are globally enabled.
        if (pending != '0) begin
          state_next = TRAP_STATE_RUN;
          if (status_mie_reg) begin
            trap      = 1'b1;
            trap_irq  = 1'b1;
            trap_code = irq_code;
          end
        end
      end
      default: begin
        if (exc_valid_i) begin
          trap      = 1'b1;
          trap_code = exc_code_i;
        end else if (status_mie_reg && irq_valid && boundary_i) begin
          trap      = 1'b1;
          trap_irq  = 1'b1;
          trap_code = irq_code;
        end else if (mret_i) begin
          status_mie_next  = status_mpie_reg;
          status_mpie_next = 1'b1;
          redirect_next    = 1'b1;
          redirect_pc_next = mepc_reg;
        end else if (wfi_i) begin
          state_next = TRAP_STATE_SLEEP;
        end else if (csr_we) begin
          case (csr_addr_i)
            CSR_MSTATUS: begin
              status_mie_next  = csr_wval[MSTATUS_MIE_BIT];
              status_mpie_next = csr_wval[MSTATUS_MPIE_BIT];
            end
            CSR_MIE:      mie_next      = csr_wval & MIE_MASK;
            CSR_MTVEC:    mtvec_next    = csr_wval & MTVEC_MASK;
            CSR_MSCRATCH: mscratch_next = csr_wval;
            CSR_MEPC:     mepc_next     = csr_wval & MEPC_MASK;
            CSR_MCAUSE:   mcause_next   = csr_wval;
            CSR_MTVAL:    mtval_next    = csr_wval;
            default: ;
          endcase
        end
      end
    endcase

    if (trap) begin
      mepc_next        = (trap_irq ? next_pc_i : exc_pc_i) & MEPC_MASK;
      mcause_next      = {trap_irq, trap_code};
      mtval_next       = trap_irq ? 32'h0 : exc_tval_i;
      status_mpie_next = status_mie_reg;
      status_mie_next  = 1'b0;
      redirect_next    = 1'b1;
      redirect_pc_next = (trap_irq && mtvec_reg[0]) ? tvec_base + {trap_code[29:0], 2'b00}
                                                    : tvec_base;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg       <= TRAP_STATE_RUN;
      status_mie_reg  <= 1'b0;
      status_mpie_reg <= 1'b0;
      mie_reg         <= '0;
      mtvec_reg       <= RESET_MTVEC;
      mscratch_reg    <= '0;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      mtval_reg       <= '0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      state_reg       <= state_next;
      status_mie_reg  <= status_mie_next;
      status_mpie_reg <= status_mpie_next;
      mie_reg         <= mie_next;
      mtvec_reg       <= mtvec_next;
      mscratch_reg    <= mscratch_next;
      mepc_reg        <= mepc_next;
      mcause_reg      <= mcause_next;
      mtval_reg       <= mtval_next;
      redirect_reg    <= redirect_next;
      redirect_pc_reg <= redirect_pc_next;
    end
  end

  assign redirect_o    = redirect_reg;
  assign redirect_pc_o = redirect_pc_reg;
  assign sleep_o       = (state_reg == TRAP_STATE_SLEEP);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed test-plan scenarios followed by randomized traffic, all checked against a
// CSR-table reference model of the trap unit.
module tb_csr_trap_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        csr_req_i;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic        csr_src_zero_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o;
  logic        exc_valid_i;
  logic [30:0] exc_code_i;
  logic [31:0] exc_pc_i, exc_tval_i;
  logic        mret_i, wfi_i, boundary_i;
  logic [31:0] next_pc_i;
  logic        irq_sw_i, irq_timer_i, irq_ext_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        sleep_o;

  always #5 clk_i = ~clk_i;

  csr_trap_unit #(.RESET_MTVEC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .csr_req_i(csr_req_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .csr_src_zero_i(csr_src_zero_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
    .exc_tval_i(exc_tval_i), .mret_i(mret_i), .wfi_i(wfi_i), .boundary_i(boundary_i),
    .next_pc_i(next_pc_i), .irq_sw_i(irq_sw_i), .irq_timer_i(irq_timer_i),
    .irq_ext_i(irq_ext_i), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .sleep_o(sleep_o)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] last_rdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: CSR contents keyed by address, plus sleep and redirect state.
  logic [31:0] m_csr [int];
  logic        m_sleep, m_redirect;
  logic [31:0] m_redirect_pc;

  function automatic logic [31:0] wmask(input int a);
    case (a)
      'h300:               return 32'h0000_0088;
      'h304:               return 32'h0000_0888;
      'h305:               return 32'hFFFF_FFFD;
      'h341:               return 32'hFFFF_FFFC;
      'h340, 'h342, 'h343: return 32'hFFFF_FFFF;
      default:             return 32'h0;
    endcase
  endfunction

  function automatic bit legal(input int a);
    return a inside {'h300, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343, 'h344};
  endfunction

  function automatic logic [31:0] mip_now();
    return {20'b0, irq_ext_i, 3'b0, irq_timer_i, 3'b0, irq_sw_i, 3'b0};
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (!legal(a)) return 32'h0;
    if (a == 'h344) return mip_now();
    if (a == 'h300) return m_csr[a] | 32'h0000_1800;
    return m_csr[a];
  endfunction

  task automatic m_write(input int a, input logic [31:0] v);
    if (a != 'h344) m_csr[a] = v & wmask(a);
  endtask

  task automatic m_reset();
    m_csr['h300] = 0; m_csr['h304] = 0; m_csr['h305] = 32'h0;
    m_csr['h340] = 0; m_csr['h341] = 0; m_csr['h342] = 0; m_csr['h343] = 0;
    m_sleep = 0; m_redirect = 0; m_redirect_pc = 0;
  endtask

  task automatic m_step();
    int order[3] = '{11, 3, 7};
    int code, a;
    logic [31:0] p, st, old, base;
    bit mie_g, do_trap, irq;
    m_redirect = 0;
    if (!rst_ni) begin
      m_reset();
      return;
    end
    a = int'(csr_addr_i);
    p = m_csr['h304] & mip_now();
    code = -1;
    for (int i = 0; i < 3; i++) if (code < 0 && p[order[i]]) code = order[i];
    st = m_csr['h300];
    mie_g = st[3];
    do_trap = 0; irq = 0;
    if (m_sleep) begin
      if (p != 0) begin
        m_sleep = 0;
        if (mie_g) begin do_trap = 1; irq = 1; end
      end
    end else if (exc_valid_i) do_trap = 1;
    else if (mie_g && p != 0 && boundary_i) begin do_trap = 1; irq = 1; end
    else if (mret_i) begin
      m_csr['h300] = 32'h80 | (st[7] ? 32'h8 : 32'h0);
      m_redirect = 1; m_redirect_pc = m_csr['h341];
    end else if (wfi_i) m_sleep = 1;
    else if (csr_req_i && legal(a)) begin
      old = m_read(a);
      case (csr_op_i[1:0])
        2'b01: m_write(a, csr_wdata_i);
        2'b10: if (!csr_src_zero_i) m_write(a, old | csr_wdata_i);
        2'b11: if (!csr_src_zero_i) m_write(a, old & ~csr_wdata_i);
        default: ;
      endcase
    end
    if (do_trap) begin
      m_write('h341, irq ? next_pc_i : exc_pc_i);
      m_csr['h342] = irq ? (32'h8000_0000 | 32'(code)) : {1'b0, exc_code_i};
      m_csr['h343] = irq ? 32'h0 : exc_tval_i;
      m_csr['h300] = mie_g ? 32'h80 : 32'h0;
      base = m_csr['h305] & 32'hFFFF_FFFC;
      m_redirect = 1;
      m_redirect_pc = (irq && m_csr['h305][0]) ? base + 32'(4 * code) : base;
    end
  endtask

  task automatic step();
    #1;
    last_rdata = csr_rdata_o;
    check_eq("rdata", csr_rdata_o, m_read(int'(csr_addr_i)));
    check_eq("illegal", {31'b0, csr_illegal_o},
             {31'b0, csr_req_i && !legal(int'(csr_addr_i))});
    @(posedge clk_i);
    m_step();
    #1;
    check_eq("redirect", {31'b0, redirect_o}, {31'b0, m_redirect});
    check_eq("redirect_pc", redirect_pc_o, m_redirect_pc);
    check_eq("sleep", {31'b0, sleep_o}, {31'b0, m_sleep});
    $display("[TB] t=%0t rst=%b req=%b op=%0d addr=%h exc=%b mret=%b wfi=%b irq=%b%b%b -> redirect=%b pc=%h sleep=%b",
             $time, rst_ni, csr_req_i, csr_op_i, csr_addr_i, exc_valid_i, mret_i, wfi_i,
             irq_ext_i, irq_sw_i, irq_timer_i, redirect_o, redirect_pc_o, sleep_o);
  endtask

  task automatic idle();
    rst_ni = 1; csr_req_i = 0; csr_op_i = 0; csr_addr_i = 12'h340; csr_wdata_i = 0;
    csr_src_zero_i = 0; exc_valid_i = 0; exc_code_i = 0; exc_pc_i = 0; exc_tval_i = 0;
    mret_i = 0; wfi_i = 0; boundary_i = 0; next_pc_i = 0;
    irq_sw_i = 0; irq_timer_i = 0; irq_ext_i = 0;
  endtask

  task automatic csr_do(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                        input logic sz);
    csr_req_i = 1; csr_op_i = op; csr_addr_i = a; csr_wdata_i = wd; csr_src_zero_i = sz;
    step();
    csr_req_i = 0; csr_src_zero_i = 0;
  endtask

  task automatic read_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_do(3'b010, a, 32'h0, 1'b1);
    check_eq(tag, last_rdata, exp);
  endtask

  initial begin
    logic [11:0] addrs [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                               12'h343, 12'h344, 12'h7C0, 12'h301};
    int codes [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 11};

    idle();
    rst_ni = 0;
    @(posedge clk_i); #1;
    m_reset();
    csr_addr_i = 12'h305;
    step();
    idle();
    read_csr("reset_mstatus", 12'h300, 32'h0000_1800);

    // Exception, direct mode
    csr_do(3'b001, 12'h305, 32'h8000_0000, 0);
    csr_do(3'b010, 12'h300, 32'h8, 0);
    exc_valid_i = 1; exc_code_i = 31'd2; exc_pc_i = 32'h100; exc_tval_i = 32'hDEAD;
    step(); idle();
    check_eq("exc_redirect", {31'b0, redirect_o}, 32'h1);
    check_eq("exc_target", redirect_pc_o, 32'h8000_0000);
    step();
    check_eq("redirect_one_cycle", {31'b0, redirect_o}, 32'h0);
    read_csr("exc_mepc", 12'h341, 32'h100);
    read_csr("exc_mcause", 12'h342, 32'h2);
    read_csr("exc_mtval", 12'h343, 32'hDEAD);
    read_csr("exc_mstatus", 12'h300, 32'h0000_1880);

    // Vectored external interrupt beats timer
    csr_do(3'b001, 12'h305, 32'h8000_0001, 0);
    csr_do(3'b001, 12'h304, 32'h880, 0);
    csr_do(3'b010, 12'h300, 32'h8, 0);
    irq_ext_i = 1; irq_timer_i = 1; boundary_i = 1; next_pc_i = 32'h204;
    step(); idle();
    check_eq("irq_target", redirect_pc_o, 32'h8000_002C);
    read_csr("irq_mcause", 12'h342, 32'h8000_000B);
    read_csr("irq_mtval", 12'h343, 32'h0);
    read_csr("irq_mepc", 12'h341, 32'h204);

    // MRET
    csr_do(3'b001, 12'h300, 32'h8, 0);
    csr_do(3'b001, 12'h341, 32'h1237, 0);
    mret_i = 1;
    step(); idle();
    check_eq("mret_target", redirect_pc_o, 32'h1234);
    read_csr("mret_mstatus", 12'h300, 32'h0000_1880);

    // Set/clear with zero source, illegal address
    csr_do(3'b001, 12'h340, 32'h0F0, 0);
    csr_do(3'b010, 12'h340, 32'hF00, 1);
    check_eq("rs_zero_rdata", last_rdata, 32'h0F0);
    read_csr("rs_zero_nowrite", 12'h340, 32'h0F0);
    csr_do(3'b011, 12'h340, 32'h0F0, 0);
    read_csr("rc_clear", 12'h340, 32'h0);
    csr_do(3'b001, 12'h7C0, 32'h1234, 0);
    check_eq("illegal_rdata", last_rdata, 32'h0);

    // WFI wake without trap, then with trap
    csr_do(3'b001, 12'h305, 32'h8000_0000, 0);
    csr_do(3'b001, 12'h300, 32'h0, 0);
    csr_do(3'b001, 12'h304, 32'h80, 0);
    wfi_i = 1; step(); idle();
    check_eq("wfi_sleep", {31'b0, sleep_o}, 32'h1);
    repeat (5) step();
    irq_timer_i = 1; step(); idle();
    check_eq("wake_sleep", {31'b0, sleep_o}, 32'h0);
    check_eq("wake_no_redirect", {31'b0, redirect_o}, 32'h0);
    csr_do(3'b001, 12'h300, 32'h8, 0);
    wfi_i = 1; step(); idle();
    repeat (5) step();
    irq_timer_i = 1; next_pc_i = 32'h300; step(); idle();
    check_eq("wake_trap", {31'b0, redirect_o}, 32'h1);
    check_eq("wake_target", redirect_pc_o, 32'h8000_0000);
    read_csr("wake_mepc", 12'h341, 32'h300);
    read_csr("wake_mcause", 12'h342, 32'h8000_0007);

    // Exception wins over a same-cycle CSR write
    exc_valid_i = 1; exc_code_i = 31'd5; exc_pc_i = 32'h400;
    csr_do(3'b001, 12'h305, 32'h1234, 0); idle();
    read_csr("exc_blocks_csr", 12'h305, 32'h8000_0000);

    // Reset while asleep
    wfi_i = 1; step(); idle();
    rst_ni = 0; step(); idle();
    check_eq("rst_sleep", {31'b0, sleep_o}, 32'h0);
    read_csr("rst_mie", 12'h304, 32'h0);
    read_csr("rst_mtvec", 12'h305, 32'h0);
    read_csr("rst_mepc", 12'h341, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      rst_ni         = ($urandom_range(0, 99) != 0);
      csr_req_i      = $urandom_range(0, 1);
      csr_op_i       = 3'($urandom);
      csr_addr_i     = addrs[$urandom_range(0, 9)];
      csr_wdata_i    = $urandom;
      csr_src_zero_i = ($urandom_range(0, 3) == 0);
      exc_valid_i    = ($urandom_range(0, 15) == 0);
      exc_code_i     = 31'(codes[$urandom_range(0, 8)]);
      exc_pc_i       = $urandom;
      exc_tval_i     = $urandom;
      mret_i         = ($urandom_range(0, 19) == 0);
      wfi_i          = ($urandom_range(0, 23) == 0);
      boundary_i     = $urandom_range(0, 1);
      next_pc_i      = $urandom;
      irq_sw_i       = ($urandom_range(0, 5) == 0);
      irq_timer_i    = ($urandom_range(0, 5) == 0);
      irq_ext_i      = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
